// File: rtl/sigmoid_pipe_if.sv
// Valid/ready stream bundle for sigmoid_pipe: activation input side,
// result output side and the saturation event counter.
interface sigmoid_pipe_if #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  in_data;
  logic                    in_mode;
  logic [TAG_W-1:0]        in_tag;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;
  logic [TAG_W-1:0]        out_tag;
  logic                    out_sat;
  logic [CNT_W-1:0]        sat_count;

  modport master (
    output in_valid, in_data, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_sat, sat_count
  );

  modport slave (
    input  in_valid, in_data, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_sat, sat_count
  );
endinterface

// File: rtl/sigmoid_pipe.sv
// Three-stage piecewise-quadratic sigmoid/tanh with saturation for |x| >= 4.0,
// per-stage valid bits with collapsing bubbles and a saturating event counter.
module sigmoid_pipe #(
  parameter int IN_W    = 8,
  parameter int IN_FRAC = 4,
  parameter int OUT_W   = 16,
  parameter int TAG_W   = 4,
  parameter int CNT_W   = 16
) (
  input  logic          clk,
  input  logic          rst,
  sigmoid_pipe_if.slave bus
);
  localparam int F  = IN_FRAC;
  localparam int AW = IN_W + 2;
  localparam int DW = F + 1;
  localparam int SW = 2 * F + 2;
  localparam logic [AW-1:0]           SAT_TH  = AW'(32'd4 << F);
  localparam logic [DW-1:0]           ONE_IN  = DW'(32'd1 << F);
  localparam logic signed [OUT_W-1:0] ONE_OUT = OUT_W'(32'd1 << (2 * F));
  localparam logic [CNT_W-1:0]        CNT_MAX = {CNT_W{1'b1}};

  logic r_v1, r_v2, r_v3;
  logic w_r1, w_r2, w_r3;

  logic             r1_neg, r1_sat, r1_mode;
  logic [DW-1:0]    r1_d;
  logic [TAG_W-1:0] r1_tag;

  logic             r2_neg, r2_sat, r2_mode;
  logic [SW-1:0]    r2_sq, r2_h;
  logic [TAG_W-1:0] r2_tag;

  logic signed [OUT_W-1:0] r_out_data;
  logic [TAG_W-1:0]        r_out_tag;
  logic                    r_out_sat;
  logic [CNT_W-1:0]        r_sat_count;

  logic signed [IN_W:0]    w_ext;
  logic [IN_W:0]           w_abs;
  logic [AW-1:0]           w_a;
  logic                    w_sat;
  logic [DW-1:0]           w_d;
  logic [SW-1:0]           w_sq;
  logic signed [OUT_W-1:0] w_sq_s, w_h_s, w_res;

  assign w_r3         = bus.out_ready || !r_v3;
  assign w_r2         = w_r3 || !r_v2;
  assign w_r1         = w_r2 || !r_v1;
  assign bus.in_ready = w_r1 && !rst;

  // One extra bit keeps |most-negative| representable; tanh doubles the argument.
  assign w_ext = {bus.in_data[IN_W-1], bus.in_data};
  assign w_abs = w_ext[IN_W] ? $unsigned(-w_ext) : $unsigned(w_ext);
  assign w_a   = bus.in_mode ? {w_abs, 1'b0} : {1'b0, w_abs};
  assign w_sat = (w_a >= SAT_TH);
  assign w_d   = ONE_IN - DW'(w_a >> 32'd2);

  assign w_sq   = SW'(r1_d) * SW'(r1_d);
  assign w_sq_s = $signed(OUT_W'(r2_sq));
  assign w_h_s  = $signed(OUT_W'(r2_h));

  // Stage-3 result selection from sign, saturation and mode.
  always_comb begin
    w_res = '0;
    if (!r2_mode) begin
      if (r2_sat) w_res = r2_neg ? '0 : ONE_OUT;
      else        w_res = r2_neg ? w_h_s : ONE_OUT - w_h_s;
    end else begin
      if (r2_sat) w_res = r2_neg ? -ONE_OUT : ONE_OUT;
      else        w_res = r2_neg ? w_sq_s - ONE_OUT : ONE_OUT - w_sq_s;
    end
  end

  // Pipeline registers; a stage only captures data when its predecessor holds a sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1 <= 1'b0; r_v2 <= 1'b0; r_v3 <= 1'b0;
      r1_neg <= 1'b0; r1_sat <= 1'b0; r1_mode <= 1'b0; r1_d <= '0; r1_tag <= '0;
      r2_neg <= 1'b0; r2_sat <= 1'b0; r2_mode <= 1'b0; r2_sq <= '0; r2_h <= '0;
      r2_tag <= '0;
      r_out_data <= '0; r_out_tag <= '0; r_out_sat <= 1'b0;
    end else begin
      if (w_r1) r_v1 <= bus.in_valid;
      if (w_r1 && bus.in_valid) begin
        r1_neg  <= bus.in_data[IN_W-1];
        r1_sat  <= w_sat;
        r1_mode <= bus.in_mode;
        r1_d    <= w_d;
        r1_tag  <= bus.in_tag;
      end
      if (w_r2) r_v2 <= r_v1;
      if (w_r2 && r_v1) begin
        r2_neg  <= r1_neg;
        r2_sat  <= r1_sat;
        r2_mode <= r1_mode;
        r2_sq   <= w_sq;
        r2_h    <= w_sq >> 32'd1;
        r2_tag  <= r1_tag;
      end
      if (w_r3) r_v3 <= r_v2;
      if (w_r3 && r_v2) begin
        r_out_data <= w_res;
        r_out_tag  <= r2_tag;
        r_out_sat  <= r2_sat;
      end
    end
  end

  // Saturated-delivery counter, sticks at its maximum.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sat_count <= '0;
    end else if (r_v3 && bus.out_ready && r_out_sat && (r_sat_count != CNT_MAX)) begin
      r_sat_count <= r_sat_count + CNT_W'(1'b1);
    end else begin
      r_sat_count <= r_sat_count;
    end
  end

  assign bus.out_valid = r_v3;
  assign bus.out_data  = r_out_data;
  assign bus.out_tag   = r_out_tag;
  assign bus.out_sat   = r_out_sat;
  assign bus.sat_count = r_sat_count;
endmodule
